// File: rtl/zxdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : zxdma_ctrl
// Description : ZX-bus DMA bridge for the NGS. It turns the asynchronous ZX
//               read/write strobes into single memory requests at an
//               auto-incrementing byte address. ZX /WAIT is held while the
//               controller is idle or busy fetching data.
// Revision    : 1.0 - initial release
// ============================================================================
// ADDR_W must be in 17..23: the top address byte is loaded from din[ADDR_W-17:0].
module zxdma_ctrl #(
  parameter int ADDR_W = 21
) (
  input  logic              cpu_clock,
  input  logic              rst_n,
  input  logic              dma_on,
  input  logic              dmaread,
  input  logic              dmawrite,
  input  logic [7:0]        dma_data_written,
  output logic [7:0]        dma_data_toberead,
  output logic              wait_ena,
  input  logic [7:0]        din,
  input  logic [2:0]        addr_wr,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [7:0]        dma_wd,
  input  logic              dma_ack,
  input  logic [7:0]        dma_rd
);

  localparam int HI_W = ADDR_W - 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_REL = 3'd2,
    WR_REL = 3'd3,
    WR_REQ = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rd_sync_q, wr_sync_q;
  logic                rs, ws;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [7:0]          wd_q, wd_d;
  logic                wait_q, wait_d;
  logic                req_q, req_d;
  logic                rnw_q, rnw_d;
  logic                addr_inc;
  logic                din_hi_unused;

  assign rs = rd_sync_q[1];
  assign ws = wr_sync_q[1];

  // Upper din bits beyond the top address byte have no destination.
  assign din_hi_unused = ^din[7:HI_W];

  // Two-flop synchronisers for the ZX strobes, then all controller state.
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= 2'b00;
      wr_sync_q <= 2'b00;
      state_q   <= IDLE;
      addr_q    <= '0;
      rdata_q   <= 8'h00;
      wd_q      <= 8'h00;
      wait_q    <= 1'b0;
      req_q     <= 1'b0;
      rnw_q     <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[0], dmaread};
      wr_sync_q <= {wr_sync_q[0], dmawrite};
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      wd_q      <= wd_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      rnw_q     <= rnw_d;
    end
  end

  // Next state, captured data, address update and next registered outputs.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    wd_d     = wd_q;
    addr_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (dma_on && rs) begin
          state_d = RD_REQ;
        end else if (dma_on && ws) begin
          state_d = WR_REL;
        end
      end
      RD_REQ: begin
        // An access in flight always completes; dma_on only picks where we go.
        if (dma_ack) begin
          rdata_d  = dma_rd;
          addr_inc = 1'b1;
          state_d  = dma_on ? RD_REL : IDLE;
        end
      end
      RD_REL: begin
        if (!dma_on || !rs) begin
          state_d = IDLE;
        end
      end
      WR_REL: begin
        if (!dma_on) begin
          state_d = IDLE;
        end else if (!ws) begin
          wd_d    = dma_data_written;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (dma_ack) begin
          addr_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A CPU address write discards any increment falling in the same cycle.
    addr_d = addr_q;
    if (|addr_wr) begin
      if (addr_wr[0]) addr_d[7:0]        = din;
      if (addr_wr[1]) addr_d[15:8]       = din;
      if (addr_wr[2]) addr_d[ADDR_W-1:16] = din[HI_W-1:0];
    end else if (addr_inc) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    // Outputs are registered copies of what the next state implies.
    wait_d = dma_on && ((state_d == IDLE) || (state_d == RD_REQ) || (state_d == WR_REQ));
    req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
    rnw_d  = (state_d != WR_REQ);
  end

  assign dma_addr          = addr_q;
  assign dma_data_toberead = rdata_q;
  assign dma_wd            = wd_q;
  assign wait_ena          = wait_q;
  assign dma_req           = req_q;
  assign dma_rnw           = rnw_q;

endmodule
`default_nettype wire

// File: tb/tb_zxdma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_zxdma_ctrl
// Description : Scoreboard bench for zxdma_ctrl. Stimulus pushes each memory
//               access it expects; a monitor pops and compares whenever the
//               DUT's request is acknowledged. A responder models the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zxdma_ctrl;

  logic        cpu_clock = 1'b0;
  logic        rst_n;
  logic        dma_on;
  logic        dmaread;
  logic        dmawrite;
  logic [7:0]  dma_data_written;
  logic [7:0]  dma_data_toberead;
  logic        wait_ena;
  logic [7:0]  din;
  logic [2:0]  addr_wr;
  logic [20:0] dma_addr;
  logic        dma_req;
  logic        dma_rnw;
  logic [7:0]  dma_wd;
  logic        dma_ack;
  logic [7:0]  dma_rd;

  typedef struct packed {
    logic        rnw;
    logic [20:0] addr;
    logic [7:0]  wd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  bit       ack_en  = 1'b1;
  int       ack_dly = 3;
  int       ack_cnt = 0;
  logic [7:0] rd_val = 8'h00;

  zxdma_ctrl #(.ADDR_W(21)) dut (
    .cpu_clock         (cpu_clock),
    .rst_n             (rst_n),
    .dma_on            (dma_on),
    .dmaread           (dmaread),
    .dmawrite          (dmawrite),
    .dma_data_written  (dma_data_written),
    .dma_data_toberead (dma_data_toberead),
    .wait_ena          (wait_ena),
    .din               (din),
    .addr_wr           (addr_wr),
    .dma_addr          (dma_addr),
    .dma_req           (dma_req),
    .dma_rnw           (dma_rnw),
    .dma_wd            (dma_wd),
    .dma_ack           (dma_ack),
    .dma_rd            (dma_rd)
  );

  always #5 cpu_clock = ~cpu_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks the ack_dly-th cycle of a request, one-cycle pulse.
  always @(negedge cpu_clock) begin
    if (!rst_n || dma_ack) begin
      dma_ack = 1'b0;
      ack_cnt = 0;
    end else if (dma_req && ack_en) begin
      if (ack_cnt == ack_dly - 1) begin
        dma_ack = 1'b1;
        dma_rd  = rd_val;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Scoreboard monitor: every acknowledged request must match the queue head.
  always @(negedge cpu_clock) begin
    #2;
    if (rst_n && dma_req && dma_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: addr 0x%0h rnw %0b, none expected", dma_addr, dma_rnw);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_rnw", {31'd0, dma_rnw}, {31'd0, mon_e.rnw});
        check("req_addr", {11'd0, dma_addr}, {11'd0, mon_e.addr});
        if (!mon_e.rnw) check("req_wd", {24'd0, dma_wd}, {24'd0, mon_e.wd});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cpu_clock);
    #1;
  endtask

  task automatic set_addr(input logic [20:0] a);
    tick(1); din = a[7:0];           addr_wr = 3'b001;
    tick(1); din = a[15:8];          addr_wr = 3'b010;
    tick(1); din = {3'b000, a[20:16]}; addr_wr = 3'b100;
    tick(1); din = 8'h00;            addr_wr = 3'b000;
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (dma_ack) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no dma_ack within 40 cycles", name);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (dma_req) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no dma_req within 40 cycles", name);
  endtask

  task automatic push(input logic rnw, input logic [20:0] a, input logic [7:0] wd);
    exp_t e;
    e.rnw  = rnw;
    e.addr = a;
    e.wd   = wd;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait_ena"}, {31'd0, wait_ena}, 32'd0);
    check({tag, "_dma_req"},  {31'd0, dma_req},  32'd0);
    check({tag, "_dma_rnw"},  {31'd0, dma_rnw},  32'd1);
    check({tag, "_dma_addr"}, {11'd0, dma_addr}, 32'd0);
    check({tag, "_dma_wd"},   {24'd0, dma_wd},   32'd0);
    check({tag, "_toberead"}, {24'd0, dma_data_toberead}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dma_on = 1'b0; dmaread = 1'b0; dmawrite = 1'b0;
    dma_data_written = 8'h00; din = 8'h00; addr_wr = 3'b000;
    dma_ack = 1'b0; dma_rd = 8'h00;

    // reset state
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // read at 0x00100
    set_addr(21'h00100);
    check("addr_load", {11'd0, dma_addr}, 32'h100);
    dma_on = 1'b1;
    tick(2);
    check("idle_wait_ena", {31'd0, wait_ena}, 32'd1);
    rd_val = 8'h5A;
    push(1'b1, 21'h00100, 8'h00);
    dmaread = 1'b1;
    wait_ack("rd1_ack");
    check("rd1_wait_in_req", {31'd0, wait_ena}, 32'd1);
    tick(1);
    check("rd1_toberead", {24'd0, dma_data_toberead}, 32'h5A);
    check("rd1_wait_rel", {31'd0, wait_ena}, 32'd0);
    check("rd1_addr", {11'd0, dma_addr}, 32'h101);
    dmaread = 1'b0;
    tick(4);
    check("rd1_wait_back", {31'd0, wait_ena}, 32'd1);

    // write of 0xC3
    dma_data_written = 8'hC3;
    dmawrite = 1'b1;
    tick(4);
    check("wr1_wait_rel", {31'd0, wait_ena}, 32'd0);
    check("wr1_no_req_yet", {31'd0, dma_req}, 32'd0);
    push(1'b0, 21'h00101, 8'hC3);
    dmawrite = 1'b0;
    wait_ack("wr1_ack");
    tick(1);
    check("wr1_addr", {11'd0, dma_addr}, 32'h102);
    check("wr1_req_done", {31'd0, dma_req}, 32'd0);
    check("wr1_wait_back", {31'd0, wait_ena}, 32'd1);

    // address wrap on a read at the top of memory
    set_addr(21'h1FFFFF);
    rd_val = 8'hA5;
    push(1'b1, 21'h1FFFFF, 8'h00);
    dmaread = 1'b1;
    wait_ack("wrap_ack");
    tick(1);
    check("wrap_addr", {11'd0, dma_addr}, 32'h0);
    check("wrap_toberead", {24'd0, dma_data_toberead}, 32'hA5);
    dmaread = 1'b0;
    tick(4);

    // CPU address load coinciding with a read ack
    set_addr(21'h00010);
    rd_val = 8'h3C;
    push(1'b1, 21'h00010, 8'h00);
    dmaread = 1'b1;
    wait_ack("coll_ack");
    din = 8'h77;
    addr_wr = 3'b001;
    tick(1);
    addr_wr = 3'b000;
    din = 8'h00;
    check("coll_addr", {11'd0, dma_addr}, 32'h77);
    check("coll_toberead", {24'd0, dma_data_toberead}, 32'h3C);
    dmaread = 1'b0;
    tick(4);

    // dma_on dropped in WR_REL: no write may follow
    dma_data_written = 8'h99;
    dmawrite = 1'b1;
    tick(4);
    dma_on = 1'b0;
    tick(2);
    check("wrrel_off_req", {31'd0, dma_req}, 32'd0);
    check("wrrel_off_wait", {31'd0, wait_ena}, 32'd0);
    dmawrite = 1'b0;
    tick(6);
    check("wrrel_off_req_after", {31'd0, dma_req}, 32'd0);
    check("wrrel_off_addr", {11'd0, dma_addr}, 32'h77);

    // dma_on dropped in RD_REQ: request held, access completes, then IDLE
    dma_on = 1'b1;
    ack_dly = 6;
    rd_val = 8'hE1;
    push(1'b1, 21'h00077, 8'h00);
    dmaread = 1'b1;
    wait_req("rdreq_off_req");
    dma_on = 1'b0;
    tick(2);
    check("rdreq_off_held", {31'd0, dma_req}, 32'd1);
    check("rdreq_off_wait", {31'd0, wait_ena}, 32'd0);
    wait_ack("rdreq_off_ack");
    tick(1);
    check("rdreq_off_addr", {11'd0, dma_addr}, 32'h78);
    check("rdreq_off_req_done", {31'd0, dma_req}, 32'd0);
    check("rdreq_off_wait_idle", {31'd0, wait_ena}, 32'd0);
    check("rdreq_off_toberead", {24'd0, dma_data_toberead}, 32'hE1);
    ack_dly = 3;
    dmaread = 1'b0;
    tick(4);

    // reset pulsed while a read request is pending
    dma_on = 1'b1;
    ack_en = 1'b0;
    dmaread = 1'b1;
    wait_req("rst_mid_req");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick(1);
    dmaread = 1'b0;
    tick(1);
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick(4);
    check("post_rst_req", {31'd0, dma_req}, 32'd0);
    check("post_rst_addr", {11'd0, dma_addr}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
